count_sample_fifo: RTL and testbench
====================================

Name: count_sample_fifo

Overview:
- Downstream consumer of the counter's `count` output.
- Samples `count` periodically (programmable divider) or on a manual trigger, and buffers the snapshots in a small FIFO.
- The management SoC drains the FIFO through a valid/ack read handshake matching the counter's bus-side convention. Status (level, overflow) is exported for LA probing.
- Lets firmware observe count history without racing the free-running counter.

Parameters:
- BITS, 32: width of sampled `count`; zero-extended or truncated to 32 bits for `rdata`.
- DEPTH, 8: FIFO entries; power of two, 2..64.
- DIV_W, 16: width of the sample-period divider.

Ports:
- clk  input  1  block clock
- reset_n  input  1  synchronous, active-low reset
- count  input  BITS  value to sample (counter output)
- enable  input  1  periodic sampling enable
- sample_div  input  DIV_W  period minus one, in cycles, between periodic samples
- trig  input  1  single-cycle manual capture request
- valid  input  1  read request (cyc & stb, non-write)
- ready  output  1  one-cycle read acknowledge
- rdata  output  32  popped sample, held until the next ack
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- empty  output  1  level == 0
- full  output  1  level == DEPTH
- overflow  output  1  sticky: a sample was dropped because the FIFO was full
- clr_ovf  input  1  clears `overflow`

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low (`reset_n`).
- Reset values (`reset_n` low at a `clk` edge):
  - pointers, level, prescaler = 0
  - `ready` = 0, `rdata` = 0, `overflow` = 0
  - `empty` = 1, `full` = 0
- Prescaler, while `enable` = 1:
  - increments each cycle.
  - When it equals `sample_div`, a periodic capture fires and the prescaler returns to 0.
  - `sample_div` = 0 captures every cycle.
  - `enable` = 0 holds the prescaler at 0; the first periodic capture then occurs `sample_div`+1 cycles after `enable` rises.
  - Changing `sample_div` mid-period takes effect on the next compare. If the prescaler already exceeds the new value, it counts up, wraps through all-ones to 0, and continues.
- Capture:
  - `trig` captures regardless of `enable`.
  - `trig` and a periodic event in the same cycle produce exactly one push.
  - The pushed value is `count` as seen at that clock edge. Entries are visible to reads on the next cycle.
- Push when full: the sample is dropped, FIFO contents are unchanged, and `overflow` is set.
  - `overflow` clears only on `clr_ovf`.
  - Set and clear in the same cycle: set wins.
- Read handshake:
  - `valid` high while `ready` is low pops the head; the next cycle `ready` = 1 for exactly one cycle with `rdata` = the popped entry.
  - `ready` is never high on two consecutive cycles. A continuously held `valid` yields one ack every 2 cycles.
  - A read while empty still acks, with `rdata` = 0 and no pointer change.
- Simultaneous push and pop:
  - `level` is unchanged.
  - When full, the pop frees the slot and the push is accepted; no overflow.
  - When empty, the pop sees empty (`rdata` = 0) and the push lands.
- Pointers wrap modulo DEPTH. `level` is maintained in a counter, not derived from pointers.
- Reset asserted mid-handshake: any pending ack is cancelled and FIFO contents are discarded.

Optional Feature:
- Macro: COUNT_SAMPLE_DELTA_EN.
- Defined:
  - Each stored entry is `count` minus the previously captured `count`, mod 2^BITS.
  - The reference register resets to 0, so the first post-reset entry equals the raw `count`.
  - The reference register updates on every capture, including dropped ones, so deltas always span consecutive capture events.
- Undefined: raw `count` values are stored; no reference register exists.

Test Plan:
- Reset, `enable` = 0, `valid` pulse -> `ready` one cycle later, `rdata` = 0, `empty` = 1, `level` = 0.
- `count` ramping +1/cycle from 0, `sample_div` = 3, `enable` = 1 for 16 cycles -> 4 entries spaced by 4 (0x3, 0x7, 0xB, 0xF with the counter starting at 0 at `enable` rise); `level` = 4.
- DEPTH = 8; fill with 10 `trig` pulses -> `full` = 1, `overflow` = 1, entries = first 8 values; `clr_ovf` -> `overflow` = 0.
- `full`; same-cycle `trig` and read -> `level` stays 8, `overflow` stays 0, oldest entry returned, new value at tail.
- `valid` held high for 10 cycles with 3 entries -> `ready` on alternate cycles, 3 data acks then acks with `rdata` = 0, `level` = 0.
- With COUNT_SAMPLE_DELTA_EN: captures at `count` = 5, 12, 0x2 (after wrap from 0xFFFFFFFF) -> entries 5, 7, 0xFFFFFFF6 (0x2 − 12 mod 2^32).

Source files
------------

// File: rtl/count_sample_fifo.sv
// count_sample_fifo
//   Snapshots a free-running counter value either periodically (programmable
//   prescaler) or on a manual trigger, and buffers the snapshots in a small
//   FIFO.
//   The SoC drains the FIFO with a valid/ack read handshake.
//
// Build option:
//   COUNT_SAMPLE_DELTA_EN - when defined, each entry holds the difference from
//   the previously captured count (mod 2^BITS) instead of the raw count.
//
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   count            value to sample
//   enable           periodic sampling enable
//   sample_div       sample period minus one, in cycles
//   trig             single-cycle manual capture request
//   valid            read request
//   ready            one-cycle read acknowledge
//   rdata            popped sample, held until the next ack
//   level            current FIFO occupancy
//   empty, full      occupancy flags
//   overflow         sticky dropped-sample flag
//   clr_ovf          clears overflow (a same-cycle set takes priority)
module count_sample_fifo #(
  parameter int BITS  = 32,
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [BITS-1:0]          count,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         sample_div,
  input  logic                     trig,
  input  logic                     valid,
  output logic                     ready,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DIV_W-1:0] presc;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [31:0]      mem [DEPTH];

  logic             periodic;
  logic             capture;
  logic             pop;
  logic             pop_data;
  logic             push;
  logic [BITS-1:0]  sample;
  logic [31:0]      sample32;

  // Prescaler: wraps naturally through all-ones if sample_div is lowered
  // below the current count, so the next compare happens after the wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (!enable) begin
      presc <= '0;
    end else if (presc == sample_div) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

  assign periodic = enable && (presc == sample_div);
  assign capture  = trig || periodic;

`ifdef COUNT_SAMPLE_DELTA_EN
  // Reference follows every capture, including dropped ones, so a delta
  // always spans two consecutive capture events.
  logic [BITS-1:0] ref_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_cnt <= '0;
    end else if (capture) begin
      ref_cnt <= count;
    end
  end

  assign sample = count - ref_cnt;
`else
  assign sample = count;
`endif

  generate
    if (BITS >= 32) begin : g_trunc
      assign sample32 = sample[31:0];
    end else begin : g_ext
      assign sample32 = {{(32-BITS){1'b0}}, sample};
    end
  endgenerate

  // A read is accepted only while no ack is outstanding, which spaces acks
  // at least two cycles apart. A pop on an empty FIFO still acks with zero.
  assign pop      = valid && !ready;
  assign pop_data = pop && (level != '0);
  // When full, a same-cycle data pop frees the slot for the push.
  assign push     = capture && ((level != LW'(DEPTH)) || pop_data);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample32;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready    <= 1'b0;
      rdata    <= '0;
      overflow <= 1'b0;
    end else begin
      ready <= pop;

      if (pop) begin
        rdata <= pop_data ? mem[rd_ptr] : '0;
      end

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (pop_data) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (push && !pop_data) begin
        level <= level + LW'(1);
      end else if (pop_data && !push) begin
        level <= level - LW'(1);
      end

      if (capture && !push) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

endmodule

// File: tb/tb_count_sample_fifo.sv
module tb_count_sample_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] count;
  logic        enable;
  logic [15:0] sample_div;
  logic        trig;
  logic        valid;
  logic        ready;
  logic [31:0] rdata;
  logic [3:0]  level;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        clr_ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  count_sample_fifo #(.BITS(32), .DEPTH(8), .DIV_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .count      (count),
    .enable     (enable),
    .sample_div (sample_div),
    .trig       (trig),
    .valid      (valid),
    .ready      (ready),
    .rdata      (rdata),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One read transaction: pulse valid, check the ack and data, then check
  // that the ack drops on the following cycle.
  task automatic read_expect(input string tag, input logic [31:0] exp);
    valid = 1'b1;
    step();
    valid = 1'b0;
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_rdata"}, rdata, exp);
    step();
    check({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  logic [31:0] exp_rd;

  initial begin
    reset_n    = 1'b0;
    count      = '0;
    enable     = 1'b0;
    sample_div = '0;
    trig       = 1'b0;
    valid      = 1'b0;
    clr_ovf    = 1'b0;
    do_reset();

    // Reset state
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // Read while empty acks with zero data
    read_expect("empty_rd", 32'd0);
    check("empty_rd_level", {28'd0, level}, 32'd0);
    check("empty_rd_empty", {31'd0, empty}, 32'd1);

`ifdef COUNT_SAMPLE_DELTA_EN
    // Delta mode: captures at 5, 12, then 2 after wrap
    count = 32'd5;
    trig  = 1'b1;
    step();
    count = 32'd12;
    step();
    count = 32'd2;
    step();
    trig  = 1'b0;
    check("dl_level", {28'd0, level}, 32'd3);
    read_expect("dl0", 32'd5);
    read_expect("dl1", 32'd7);
    read_expect("dl2", 32'hFFFF_FFF6);
`else
    // Periodic sampling, sample_div = 3, count ramps from 0 at enable rise
    sample_div = 16'd3;
    enable     = 1'b1;
    count      = 32'd0;
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("per_level_%0d", k), {28'd0, level}, (k + 1) / 4);
      count = count + 32'd1;
    end
    enable = 1'b0;
    read_expect("per0", 32'h3);
    read_expect("per1", 32'h7);
    read_expect("per2", 32'hB);
    read_expect("per3", 32'hF);
    check("per_empty", {31'd0, empty}, 32'd1);

    // Fill with 10 triggers: last two dropped
    trig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      count = 32'h100 + i;
      step();
    end
    trig = 1'b0;
    check("fill_level", {28'd0, level}, 32'd8);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_ovf", {31'd0, overflow}, 32'd1);

    // Set and clear in the same cycle: set wins
    trig    = 1'b1;
    clr_ovf = 1'b1;
    count   = 32'h1FF;
    step();
    trig = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    step();
    clr_ovf = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // Full: simultaneous push and pop
    count = 32'h200;
    trig  = 1'b1;
    valid = 1'b1;
    step();
    trig  = 1'b0;
    valid = 1'b0;
    check("fpp_ready", {31'd0, ready}, 32'd1);
    check("fpp_rdata", rdata, 32'h100);
    check("fpp_level", {28'd0, level}, 32'd8);
    check("fpp_ovf", {31'd0, overflow}, 32'd0);
    step();

    for (int i = 1; i <= 5; i++) begin
      read_expect($sformatf("drain%0d", i), 32'h100 + i);
    end
    check("drain_level", {28'd0, level}, 32'd3);

    // Held valid: ack on alternate cycles, 3 data then zeros
    valid  = 1'b1;
    exp_rd = rdata;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c % 2 == 0) begin
        case (c)
          0:       exp_rd = 32'h106;
          2:       exp_rd = 32'h107;
          4:       exp_rd = 32'h200;
          default: exp_rd = 32'd0;
        endcase
      end
      check($sformatf("hold_ready_%0d", c), {31'd0, ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("hold_rdata_%0d", c), rdata, exp_rd);
    end
    valid = 1'b0;
    step();
    check("hold_level", {28'd0, level}, 32'd0);
    check("hold_empty", {31'd0, empty}, 32'd1);

    // Empty: simultaneous push and pop
    count = 32'h300;
    trig  = 1'b1;
    valid = 1'b1;
    step();
    trig  = 1'b0;
    valid = 1'b0;
    check("epp_ready", {31'd0, ready}, 32'd1);
    check("epp_rdata", rdata, 32'd0);
    check("epp_level", {28'd0, level}, 32'd1);
    step();
    read_expect("epp_pop", 32'h300);
`endif

    // Reset during a read request discards contents and cancels the ack
    count = 32'h400;
    trig  = 1'b1;
    step();
    step();
    trig = 1'b0;
    check("mr_level_pre", {28'd0, level}, 32'd2);
    valid   = 1'b1;
    reset_n = 1'b0;
    step();
    valid   = 1'b0;
    reset_n = 1'b1;
    check("mr_ready", {31'd0, ready}, 32'd0);
    check("mr_level", {28'd0, level}, 32'd0);
    check("mr_rdata", rdata, 32'd0);
    read_expect("mr_rd", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
